sram_arbiter: RTL

Two-requester arbiter and access sequencer for the board's 256K×16 asynchronous SRAM, used by the ADR/DAT/RAMOE/RAMWE/RAMCS pins. Requesters A and B submit single-word reads/writes through a valid/ready handshake. The block grants them round-robin, drives the SRAM strobes with a fixed setup/access/hold sequence, and returns a one-cycle response. It sits between the top level, which owns the DAT tristate, and the application logic.

---
 rtl/sram_pkg.sv | 30 +++
 rtl/sram_arbiter_rr.sv | 43 ++++
 rtl/sram_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Requester identifier, also used as the round-robin pointer
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // The requester that did not win; the pointer moves here after a grant
    function automatic req_id_t other_req(input req_id_t id);
        case (id)
            REQ_A:   return REQ_B;
            REQ_B:   return REQ_A;
            default: return REQ_A;
        endcase
    endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer for the next decision.
import sram_pkg::*;

module rr_arbiter_2 (
    input  logic       a_valid,
    input  logic       b_valid,
    input  req_id_t    ptr,
    input  logic       advance,
    output logic [1:0] grant,
    output req_id_t    ptr_next
);

    // Pick the winner: pointer breaks ties, a lone requester always wins
    always_comb begin
        grant = 2'b00;
        if (a_valid && b_valid) begin
            if (ptr == REQ_A) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (a_valid) begin
            grant = 2'b01;
        end else if (b_valid) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

    // After a grant the pointer moves to the requester that lost (or was absent)
    always_comb begin
        ptr_next = ptr;
        if (advance && grant[0]) begin
            ptr_next = other_req(REQ_A);
        end else if (advance && grant[1]) begin
            ptr_next = other_req(REQ_B);
        end else begin
            ptr_next = ptr;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter and fixed-timing access sequencer for a 256Kx16 async SRAM.
// Strobes are registered from the next state so each state's pin levels are
// present for the whole cycle the FSM spends in it, with no combinational glitches.
import sram_pkg::*;

module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    input  logic                   a_we,
    input  logic [SRAM_ADDR_W-1:0] a_addr,
    input  logic [SRAM_DATA_W-1:0] a_wdata,
    output logic                   a_ready,
    output logic                   a_rsp_valid,
    input  logic                   b_valid,
    input  logic                   b_we,
    input  logic [SRAM_ADDR_W-1:0] b_addr,
    input  logic [SRAM_DATA_W-1:0] b_wdata,
    output logic                   b_ready,
    output logic                   b_rsp_valid,
    output logic [SRAM_DATA_W-1:0] rsp_rdata,
    output logic [SRAM_ADDR_W-1:0] sram_adr,
    output logic [SRAM_DATA_W-1:0] sram_dat_out,
    output logic                   sram_dat_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dat_in,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_cs_n
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [3:0]             cnt_r;
    req_id_t                ptr_r;
    req_id_t                ptr_next_s;
    req_id_t                owner_r;
    logic                   req_we_r;
    logic [1:0]             grant_s;
    logic                   idle_s;
    logic                   accept_s;
    logic                   last_access_s;
    logic                   sel_we_s;
    logic [SRAM_ADDR_W-1:0] sel_addr_s;
    logic [SRAM_DATA_W-1:0] sel_wdata_s;
    logic                   we_next_s;
    logic                   cs_n_s;
    logic                   oe_n_s;
    logic                   we_n_s;
    logic                   dat_oe_s;
    logic [SRAM_ADDR_W-1:0] sram_adr_r;
    logic [SRAM_DATA_W-1:0] sram_dat_out_r;
    logic                   sram_dat_oe_r;
    logic                   sram_oe_n_r;
    logic                   sram_we_n_r;
    logic                   sram_cs_n_r;
    logic [SRAM_DATA_W-1:0] rsp_rdata_r;
    logic                   a_rsp_valid_r;
    logic                   b_rsp_valid_r;

    // Requests are only considered in IDLE and never while reset is held
    always_comb begin
        idle_s        = (state_r == IDLE) && rst;
        accept_s      = |grant_s;
        last_access_s = (state_r == ACCESS) && (cnt_r == CNT_LAST);
    end

    rr_arbiter_2 u_rr (
        .a_valid  (a_valid && idle_s),
        .b_valid  (b_valid && idle_s),
        .ptr      (ptr_r),
        .advance  (idle_s),
        .grant    (grant_s),
        .ptr_next (ptr_next_s)
    );

    // Ready pulses are the grant itself, so they stay combinational
    always_comb begin
        a_ready = grant_s[0];
        b_ready = grant_s[1];
    end

    // Mux the winning requester's fields for latching on accept
    always_comb begin
        sel_we_s    = a_we;
        sel_addr_s  = a_addr;
        sel_wdata_s = a_wdata;
        if (grant_s[1]) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
        if (accept_s) begin
            we_next_s = sel_we_s;
        end else begin
            we_next_s = req_we_r;
        end
    end

    // Next-state logic for the setup/access/hold sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                state_next_s = ACCESS;
            end
            ACCESS: begin
                if (last_access_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            HOLD: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Pin levels for the state being entered; OE and WE are never low together
    always_comb begin
        cs_n_s   = 1'b1;
        oe_n_s   = 1'b1;
        we_n_s   = 1'b1;
        dat_oe_s = 1'b0;
        case (state_next_s)
            IDLE: begin
                cs_n_s   = 1'b1;
            end
            SETUP: begin
                cs_n_s   = 1'b0;
                oe_n_s   = we_next_s;
                dat_oe_s = we_next_s;
            end
            ACCESS: begin
                cs_n_s   = 1'b0;
                oe_n_s   = we_next_s;
                we_n_s   = ~we_next_s;
                dat_oe_s = we_next_s;
            end
            HOLD: begin
                // Writes keep CS and data driven past the WE rising edge
                cs_n_s   = ~we_next_s;
                dat_oe_s = we_next_s;
            end
            default: begin
                cs_n_s   = 1'b1;
            end
        endcase
    end

    // FSM state, wait counter, pointer and latched request attributes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            ptr_r    <= REQ_A;
            owner_r  <= REQ_A;
            req_we_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            if ((state_r == ACCESS) && (state_next_s == ACCESS)) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= 4'd0;
            end
            if (accept_s) begin
                owner_r  <= grant_s[1] ? REQ_B : REQ_A;
                req_we_r <= sel_we_s;
            end else begin
                owner_r  <= owner_r;
                req_we_r <= req_we_r;
            end
        end
    end

    // SRAM-side output registers; address and data hold their last value in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_adr_r     <= 18'd0;
            sram_dat_out_r <= 16'd0;
            sram_dat_oe_r  <= 1'b0;
            sram_oe_n_r    <= 1'b1;
            sram_we_n_r    <= 1'b1;
            sram_cs_n_r    <= 1'b1;
        end else begin
            if (accept_s) begin
                sram_adr_r     <= sel_addr_s;
                sram_dat_out_r <= sel_wdata_s;
            end else begin
                sram_adr_r     <= sram_adr_r;
                sram_dat_out_r <= sram_dat_out_r;
            end
            sram_dat_oe_r <= dat_oe_s;
            sram_oe_n_r   <= oe_n_s;
            sram_we_n_r   <= we_n_s;
            sram_cs_n_r   <= cs_n_s;
        end
    end

    // Response pulse for the owner on entry to HOLD; read data captured at the end of ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata_r   <= 16'd0;
            a_rsp_valid_r <= 1'b0;
            b_rsp_valid_r <= 1'b0;
        end else begin
            a_rsp_valid_r <= (state_next_s == HOLD) && (state_r == ACCESS) && (owner_r == REQ_A);
            b_rsp_valid_r <= (state_next_s == HOLD) && (state_r == ACCESS) && (owner_r == REQ_B);
            if (last_access_s && !req_we_r) begin
                rsp_rdata_r <= sram_dat_in;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign sram_adr     = sram_adr_r;
    assign sram_dat_out = sram_dat_out_r;
    assign sram_dat_oe  = sram_dat_oe_r;
    assign sram_oe_n    = sram_oe_n_r;
    assign sram_we_n    = sram_we_n_r;
    assign sram_cs_n    = sram_cs_n_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign a_rsp_valid  = a_rsp_valid_r;
    assign b_rsp_valid  = b_rsp_valid_r;

endmodule
